// File: rtl/pixel_float_loader_if.sv
// Output stream of pixel_float_loader: one converted pixel per transfer.
// The transfer happens when out_valid and out_ready are both high.
interface pixel_float_loader_if #(
    parameter int AW = 10
);
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [AW-1:0] out_idx;
    logic          out_last;

    modport master (
        output out_valid, out_data, out_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_idx, out_last,
        output out_ready
    );
endinterface

// File: rtl/pixel_float_loader.sv
// Streams one image of 8-bit pixels from the pixel RAM as IEEE-754 singles.
// A 2-entry output FIFO with read credits lets the consumer apply backpressure.
module pixel_float_loader #(
    parameter int NPIX = 784,
    parameter int AW   = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    pixel_float_loader_if.master ostr
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [AW:0]   NPIX_W   = (AW+1)'(NPIX);
    localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);

    state_t        state_q, state_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] fl_idx_q, fl_idx_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          head_q, head_d;

    logic [31:0]   fdata_q [2];
    logic [AW-1:0] fidx_q  [2];
    logic          flast_q [2];

    logic          valid, pop, push, wr_sel;
    logic [2:0]    credit_used;
    logic [2:0]    msb;
    logic [7:0]    norm;
    logic [31:0]   conv;

    // Exact u8 -> float: normalise so the leading one sits at bit 7, then drop it.
    always_comb begin
        msb = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mem_rdata[i]) msb = 3'(i);
        end
        norm = mem_rdata << (3'd7 - msb);
        conv = (mem_rdata == 8'd0) ? '0 : {1'b0, 8'd127 + {5'd0, msb}, norm[6:0], 16'd0};
    end

    assign valid       = (cnt_q != 2'd0);
    assign pop         = valid & ostr.out_ready;
    assign push        = (state_q == RUN) & inflight_q & ~abort;
    assign wr_sel      = head_q ^ cnt_q[0];
    assign credit_used = {1'b0, cnt_q} + {2'b0, inflight_q};

    assign busy          = (state_q == RUN);
    assign mem_addr      = rd_ptr_q[AW-1:0];
    assign mem_rd        = (state_q == RUN) & (rd_ptr_q < NPIX_W) &
                           (credit_used < (3'd2 + {2'b0, pop}));
    assign done          = (state_q == RUN) & pop & flast_q[head_q] & ~abort;
    assign ostr.out_valid = valid;
    assign ostr.out_data  = fdata_q[head_q];
    assign ostr.out_idx   = fidx_q[head_q];
    assign ostr.out_last  = flast_q[head_q];

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        fl_idx_d   = fl_idx_q;
        inflight_d = inflight_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        case (state_q)
            IDLE: begin
                inflight_d = 1'b0;
                if (start && !abort) begin
                    state_d  = RUN;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                    head_d   = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d    = IDLE;
                    rd_ptr_d   = '0;
                    inflight_d = 1'b0;
                    cnt_d      = '0;
                    head_d     = 1'b0;
                end else begin
                    inflight_d = mem_rd;
                    if (mem_rd) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        fl_idx_d = rd_ptr_q[AW-1:0];
                    end
                    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
                    head_d = head_q ^ pop;
                    if (done) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            fl_idx_q   <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            head_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            fl_idx_q   <= fl_idx_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fdata_q[i] <= '0;
                fidx_q[i]  <= '0;
                flast_q[i] <= 1'b0;
            end
        end else if (push) begin
            fdata_q[wr_sel] <= conv;
            fidx_q[wr_sel]  <= fl_idx_q;
            flast_q[wr_sel] <= (fl_idx_q == LAST_IDX);
        end
    end
endmodule
